min_receive_fsm: RTL

- Decodes MIN-framed byte streams arriving from the UART receiver.
- Strips header and byte-stuffing, checks CRC-32 and delivers the identifier and payload of each valid frame as a single-cycle strobe.
- Sits between the UART `received`/`rx_byte` outputs and command-handling logic, on the `sclk` domain.
- Complement of `min_transmit_fsm`, which encodes outgoing frames with the same format.

---
 rtl/min_pkg.sv | 37 +++
 rtl/min_crc32.sv | 32 +++
 rtl/min_receive_fsm.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/min_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | min_pkg: framing constants, FSM state encoding and byte-wide CRC-32 step    |
// | shared by the MIN receive and transmit paths.                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package min_pkg;

  localparam logic [7:0]  MIN_HEADER_BYTE = 8'hAA;
  localparam logic [7:0]  MIN_STUFF_BYTE  = 8'h55;
  localparam logic [7:0]  MIN_EOF_BYTE    = 8'h55;
  localparam logic [31:0] MIN_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] MIN_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] MIN_CRC_XOROUT  = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    ID      = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CRC     = 3'd4,
    EOF     = 3'd5
  } min_state_e;

  // Reflected CRC-32, LSB first, one byte per call.
  function automatic logic [31:0] min_crc32_byte(input logic [31:0] crc,
                                                 input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ MIN_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/min_crc32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | min_crc32: byte-wide CRC-32 accumulator with synchronous clear and enable. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module min_crc32
  import min_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc <= MIN_CRC_INIT;
    end else if (i_clr) begin
      r_crc <= MIN_CRC_INIT;
    end else if (i_en) begin
      r_crc <= min_crc32_byte(r_crc, i_data);
    end
  end

  assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/min_receive_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | min_receive_fsm: MIN frame decoder (header sync, unstuffing, CRC-32 check) |
// | delivering id/len/payload of each accepted frame. Optional CRC checking    |
// | is enabled by defining MIN_RX_CRC_CHECK_EN.                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module min_receive_fsm
  import min_pkg::*;
#(
  parameter int N_DATA_BYTE = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [7:0]               i_data,
  output logic [7:0]               o_id,
  output logic [7:0]               o_len,
  output logic [8*N_DATA_BYTE-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_crc_err,
  output logic                     o_frame_err,
  output logic                     o_busy
);

  localparam int         c_data_w  = 8 * N_DATA_BYTE;
  localparam logic [7:0] c_max_len = 8'(N_DATA_BYTE);

  min_state_e            r_state, w_state_nxt;
  logic [1:0]            r_aa_cnt, w_aa_cnt_nxt;
  logic [7:0]            r_sh_id, w_sh_id_nxt;
  logic [7:0]            r_sh_len, w_sh_len_nxt;
  logic [c_data_w-1:0]   r_sh_data, w_sh_data_nxt;
  logic [7:0]            r_pay_cnt, w_pay_cnt_nxt;
  logic [1:0]            r_crc_cnt, w_crc_cnt_nxt;
  logic [31:0]           r_rx_crc, w_rx_crc_nxt;
  logic [7:0]            r_id, w_id_nxt;
  logic [7:0]            r_len, w_len_nxt;
  logic [c_data_w-1:0]   r_data, w_data_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_crc_err, w_crc_err_nxt;
  logic                  r_frame_err, w_frame_err_nxt;
  logic                  w_crc_clr, w_crc_en, w_crc_ok;
  logic                  w_take, w_restart;
  logic [N_DATA_BYTE-1:0] w_byte_sel;

  // Payload byte k lands in the k-th byte from the top of the shadow word.
  for (genvar g = 0; g < N_DATA_BYTE; g++) begin : g_byte_sel
    assign w_byte_sel[g] = (r_pay_cnt == 8'(N_DATA_BYTE - 1 - g));
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_aa_cnt_nxt    = r_aa_cnt;
    w_sh_id_nxt     = r_sh_id;
    w_sh_len_nxt    = r_sh_len;
    w_sh_data_nxt   = r_sh_data;
    w_pay_cnt_nxt   = r_pay_cnt;
    w_crc_cnt_nxt   = r_crc_cnt;
    w_rx_crc_nxt    = r_rx_crc;
    w_id_nxt        = r_id;
    w_len_nxt       = r_len;
    w_data_nxt      = r_data;
    w_valid_nxt     = 1'b0;
    w_crc_err_nxt   = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_crc_clr       = 1'b0;
    w_crc_en        = 1'b0;
    w_take          = 1'b0;
    w_restart       = 1'b0;

    if (i_valid) begin
      if (r_state == HUNT) begin
        if (i_data == MIN_HEADER_BYTE) begin
          if (r_aa_cnt == 2'd2) w_restart = 1'b1;
          else                  w_aa_cnt_nxt = r_aa_cnt + 2'd1;
        end else begin
          w_aa_cnt_nxt = 2'd0;
        end
      end else if (r_aa_cnt == 2'd2) begin
        // Byte following two body AAs: stuff, header, or a broken stream.
        if (i_data == MIN_STUFF_BYTE) begin
          w_aa_cnt_nxt = 2'd0;
        end else if (i_data == MIN_HEADER_BYTE) begin
          w_restart = 1'b1;
        end else begin
          w_frame_err_nxt = 1'b1;
          w_state_nxt     = HUNT;
          w_aa_cnt_nxt    = 2'd0;
        end
      end else begin
        w_aa_cnt_nxt = (i_data == MIN_HEADER_BYTE) ? r_aa_cnt + 2'd1 : 2'd0;
        w_take       = 1'b1;
      end
    end

    if (w_take) begin
      case (r_state)
        ID: begin
          w_sh_id_nxt = i_data;
          w_crc_en    = 1'b1;
          w_state_nxt = LEN;
        end
        LEN: begin
          w_sh_len_nxt  = i_data;
          w_pay_cnt_nxt = 8'd0;
          w_crc_cnt_nxt = 2'd0;
          if (i_data > c_max_len) begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = HUNT;
          end else begin
            w_crc_en    = 1'b1;
            w_state_nxt = (i_data == 8'd0) ? CRC : PAYLOAD;
          end
        end
        PAYLOAD: begin
          for (int b = 0; b < N_DATA_BYTE; b++) begin
            if (w_byte_sel[b]) w_sh_data_nxt[8*b +: 8] = i_data;
          end
          w_crc_en      = 1'b1;
          w_pay_cnt_nxt = r_pay_cnt + 8'd1;
          if (r_pay_cnt + 8'd1 == r_sh_len) w_state_nxt = CRC;
        end
        CRC: begin
          w_rx_crc_nxt  = {r_rx_crc[23:0], i_data};
          w_crc_cnt_nxt = r_crc_cnt + 2'd1;
          if (r_crc_cnt == 2'd3) w_state_nxt = EOF;
        end
        EOF: begin
          w_state_nxt = HUNT;
          if (i_data != MIN_EOF_BYTE) begin
            w_frame_err_nxt = 1'b1;
          end else if (!w_crc_ok) begin
            w_crc_err_nxt = 1'b1;
          end else begin
            w_valid_nxt = 1'b1;
            w_id_nxt    = r_sh_id;
            w_len_nxt   = r_sh_len;
            w_data_nxt  = r_sh_data;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end

    // Three consecutive AAs restart a frame from anywhere, discarding progress.
    if (w_restart) begin
      w_state_nxt   = ID;
      w_aa_cnt_nxt  = 2'd0;
      w_sh_id_nxt   = 8'd0;
      w_sh_len_nxt  = 8'd0;
      w_sh_data_nxt = '0;
      w_pay_cnt_nxt = 8'd0;
      w_crc_cnt_nxt = 2'd0;
      w_rx_crc_nxt  = 32'd0;
      w_crc_clr     = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= HUNT;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aa_cnt    <= 2'd0;
      r_sh_id     <= 8'd0;
      r_sh_len    <= 8'd0;
      r_sh_data   <= '0;
      r_pay_cnt   <= 8'd0;
      r_crc_cnt   <= 2'd0;
      r_rx_crc    <= 32'd0;
      r_id        <= 8'd0;
      r_len       <= 8'd0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_crc_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_aa_cnt    <= w_aa_cnt_nxt;
      r_sh_id     <= w_sh_id_nxt;
      r_sh_len    <= w_sh_len_nxt;
      r_sh_data   <= w_sh_data_nxt;
      r_pay_cnt   <= w_pay_cnt_nxt;
      r_crc_cnt   <= w_crc_cnt_nxt;
      r_rx_crc    <= w_rx_crc_nxt;
      r_id        <= w_id_nxt;
      r_len       <= w_len_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_crc_err   <= w_crc_err_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

`ifdef MIN_RX_CRC_CHECK_EN
  logic [31:0] w_crc;

  min_crc32 u_crc32 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_crc_clr),
    .i_en    (w_crc_en),
    .i_data  (i_data),
    .o_crc   (w_crc)
  );

  assign w_crc_ok  = (r_rx_crc == (w_crc ^ MIN_CRC_XOROUT));
  assign o_crc_err = r_crc_err;
`else
  logic w_unused_crc;
  assign w_unused_crc = ^{w_crc_clr, w_crc_en, r_rx_crc, r_crc_err};
  assign w_crc_ok     = 1'b1;
  assign o_crc_err    = 1'b0;
`endif

  assign o_id        = r_id;
  assign o_len       = r_len;
  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state != HUNT);

endmodule
`default_nettype wire
